age_stamp_alloc_3: RTL and testbench
====================================

# age_stamp_alloc_3

Three-entry age-stamped holding buffer that feeds the 3-way oldest-first selector. Accepts payloads on a valid/ready allocate port, stamps each with a monotonically increasing age, and presents per-slot valid/age to the selector (smaller age = older = higher priority). Takes back the selector's one-hot grant, frees that slot and issues its payload one cycle later. When the stamp counter nears overflow, a rebase state renormalises all live ages so the unsigned age compare stays correct.

## Interface
- DW, 8, payload width
- AW, 5, age/stamp width; max stamp AMAX = 2^AW-1 (31)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- alloc_vld  in  1  allocate request
- alloc_rdy  out  1  slot available and not rebasing
- alloc_data  in  DW  payload to store
- slot_vld  out  3  per-slot occupied, to selector in_vld
- slot_age  out  3 x AW  per-slot age, to selector in_age
- grant  in  3  one-hot (or zero) select from selector out_vld
- iss_vld  out  1  issue strobe, registered
- iss_data  out  DW  issued payload
- iss_age  out  AW  age of issued entry at grant time
- err  out  1  sticky protocol error (only with AGE_STAMP_ERR_EN)

## Operation
- State: slot_vld[2:0], slot_age[3], slot_data[3], stamp (AW bits), FSM {RUN, REBASE}.
- Reset values: slot_vld=0, ages=0, data=0, stamp=0, FSM=RUN, iss_vld=0, iss_data=0, iss_age=0, err=0.
- alloc_rdy = (FSM==RUN) && (slot_vld != 3'b111); uses registered occupancy only.
- Allocate fires on alloc_vld && alloc_rdy: lowest-index free slot gets valid=1, age=stamp, data=alloc_data; stamp increments by 1.
- Grant: if grant[i] && slot_vld[i], slot i is cleared at the edge; iss_vld=1, iss_data/iss_age = slot i contents next cycle. grant==0 -> iss_vld=0.
- Grant and allocate in the same cycle are both honoured. The freed slot is not reused that cycle; allocate takes a different free slot.
- RUN -> REBASE when the post-update stamp equals AMAX.
- REBASE, each cycle: m = min age over slots valid and not granted this cycle (m = stamp if none). Every surviving age -= m, stamp -= m. If the new stamp < AMAX go to RUN, else stay.
- Grants are accepted in REBASE and are applied in the same cycle as the subtraction.
- Invariants: every live age < stamp <= AMAX, and all ages are distinct. Subtraction never underflows.
- Full: alloc_rdy=0 until a grant frees a slot; rdy rises the cycle after the grant edge.
- Grant to an invalid slot: ignored, no issue.
- Non-one-hot grant: lowest set index is honoured.

## Timing
- Allocate to slot_vld visible: 1 cycle.
- Grant to iss_vld: 1 cycle. Slot is invisible to the selector the cycle after the grant.
- Rebase: minimum 1 cycle of alloc_rdy=0; repeats while the oldest live entry pins stamp at AMAX.
- Reset mid-operation: all entries are dropped immediately. A pending issue is lost and iss_vld is forced to 0 asynchronously.

## Configuration
- AGE_STAMP_ERR_EN defined: err is driven. It sets sticky (until rst) on a grant with more than one bit set, a grant to an invalid slot, or alloc_vld with a data change while stalled and !alloc_rdy. Otherwise behaviour is unchanged.
- Not defined: err is tied to 0 and the checking logic is absent.

## Structure
- Shared package: AW/DW defaults, AMAX constant, FSM enum {RUN, REBASE}, slot struct {vld, age, data}.
- One natural sub-module, age_min_3: combinational masked minimum over three AW-bit ages, returning the min and an any-valid flag. It is reused by the rebase path.

## Test plan
- Reset, alloc A,B,C back-to-back -> slots 0,1,2 ages 0,1,2, stamp=3, alloc_rdy=0 after third.
- Full buffer, grant=3'b001 -> next cycle iss_vld=1 iss_data=A iss_age=0, slot_vld=3'b110, alloc_rdy=1 the following cycle.
- Same-cycle alloc D and grant 3'b010 with slot 0 free -> D to slot 0 age 3, B issued, slot_vld=3'b101.
- Drive stamp to 31 with live ages {28,30} -> REBASE one cycle, ages {0,2}, stamp=3, back to RUN, alloc_rdy=0 exactly one cycle.
- Entry age 0 held while 31 allocs/grants cycle other slots -> stamp pins at 31, FSM stays REBASE; grant the age-0 slot -> rebase completes next cycle.
- With AGE_STAMP_ERR_EN, grant=3'b011 -> slot 0 issued, err=1 and stays 1 until rst; without the macro, err=0.

Source files
------------

// File: rtl/age_stamp_alloc_3_pkg.sv
// Shared types and constants for the three-entry age-stamped holding buffer.
// Optional error checking in the top is enabled by defining AGE_STAMP_ERR_EN.
package age_stamp_alloc_3_pkg;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam logic [AW-1:0] AMAX = {AW{1'b1}};

    typedef enum logic {
        RUN    = 1'b0,
        REBASE = 1'b1
    } state_t;

    typedef struct packed {
        logic          vld;
        logic [AW-1:0] age;
        logic [DW-1:0] data;
    } slot_t;

endpackage

// File: rtl/age_stamp_alloc_3_min.sv
// Combinational masked minimum over three ages, with an any-valid flag.
// Used by the rebase path to find the oldest surviving entry.
module age_min_3
    import age_stamp_alloc_3_pkg::*;
#(
    parameter int W = AW
) (
    input  logic [2:0]        vld,
    input  logic [2:0][W-1:0] age,
    output logic [W-1:0]      min_age,
    output logic              any
);

    always_comb begin
        min_age = '1;
        any     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (vld[i] && (!any || age[i] < min_age)) begin
                min_age = age[i];
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/age_stamp_alloc_3.sv
// Three-entry age-stamped holding buffer feeding an oldest-first selector.
// Define AGE_STAMP_ERR_EN to drive the sticky protocol error output.
module age_stamp_alloc_3
    import age_stamp_alloc_3_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_vld,
    output logic                 alloc_rdy,
    input  logic [DW-1:0]        alloc_data,
    output logic [2:0]           slot_vld,
    output logic [2:0][AW-1:0]   slot_age,
    input  logic [2:0]           grant,
    output logic                 iss_vld,
    output logic [DW-1:0]        iss_data,
    output logic [AW-1:0]        iss_age,
    output logic                 err
);

    slot_t         slots [3];
    state_t        state;
    logic [AW-1:0] stamp;

    logic [2:0]    gsel;
    logic [2:0]    gmask;
    logic          g_hit;
    logic [2:0]    fsel;
    logic          fire;
    logic [2:0]    surv;
    logic [AW-1:0] mn;
    logic          any_live;
    logic [AW-1:0] m;
    logic [AW-1:0] stamp_inc;
    logic [AW-1:0] stamp_reb;
    logic [DW-1:0] iss_d_n;
    logic [AW-1:0] iss_a_n;

    for (genvar i = 0; i < 3; i++) begin : g_out
        assign slot_vld[i] = slots[i].vld;
        assign slot_age[i] = slots[i].age;
    end

    assign alloc_rdy = (state == RUN) && (slot_vld != 3'b111);
    assign fire      = alloc_vld && alloc_rdy;

    // Non-one-hot grants honour the lowest set index.
    always_comb begin
        priority case (1'b1)
            grant[0]: gsel = 3'b001;
            grant[1]: gsel = 3'b010;
            grant[2]: gsel = 3'b100;
            default:  gsel = 3'b000;
        endcase
    end

    assign gmask = gsel & slot_vld;
    assign g_hit = |gmask;

    // Free slot comes from registered occupancy, so a slot granted this
    // cycle still looks busy and is never reused in the same cycle.
    always_comb begin
        priority case (1'b1)
            !slot_vld[0]: fsel = 3'b001;
            !slot_vld[1]: fsel = 3'b010;
            !slot_vld[2]: fsel = 3'b100;
            default:      fsel = 3'b000;
        endcase
    end

    always_comb begin
        iss_d_n = '0;
        iss_a_n = '0;
        for (int i = 0; i < 3; i++) begin
            if (gmask[i]) begin
                iss_d_n = slots[i].data;
                iss_a_n = slots[i].age;
            end
        end
    end

    assign surv = slot_vld & ~gmask;

    age_min_3 #(.W(AW)) u_min (
        .vld     (surv),
        .age     (slot_age),
        .min_age (mn),
        .any     (any_live)
    );

    assign m         = any_live ? mn : stamp;
    assign stamp_inc = stamp + AW'(fire);
    assign stamp_reb = stamp - m;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) slots[i] <= '0;
            state    <= RUN;
            stamp    <= '0;
            iss_vld  <= 1'b0;
            iss_data <= '0;
            iss_age  <= '0;
        end else begin
            iss_vld <= g_hit;
            if (g_hit) begin
                iss_data <= iss_d_n;
                iss_age  <= iss_a_n;
            end
            for (int i = 0; i < 3; i++) begin
                if (gmask[i]) slots[i].vld <= 1'b0;
            end
            unique case (state)
                RUN: begin
                    for (int i = 0; i < 3; i++) begin
                        if (fire && fsel[i]) begin
                            slots[i] <= '{vld: 1'b1, age: stamp, data: alloc_data};
                        end
                    end
                    stamp <= stamp_inc;
                    if (stamp_inc == AMAX) state <= REBASE;
                end
                REBASE: begin
                    // m is the oldest survivor, so no age can underflow.
                    for (int i = 0; i < 3; i++) begin
                        if (surv[i]) slots[i].age <= slots[i].age - m;
                    end
                    stamp <= stamp_reb;
                    if (stamp_reb < AMAX) state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef AGE_STAMP_ERR_EN
    logic          stall_q;
    logic [DW-1:0] data_q;
    logic          err_q;
    logic          bad;

    assign bad = ((grant & (grant - 3'd1)) != 3'b000)
              || ((grant & ~slot_vld) != 3'b000)
              || (stall_q && alloc_vld && (alloc_data != data_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= alloc_vld && !alloc_rdy;
            data_q  <= alloc_data;
            if (bad) err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_age_stamp_alloc_3.sv
// Scoreboarded bench for age_stamp_alloc_3; issues are checked against a queue.
// Expected err value follows AGE_STAMP_ERR_EN.
module tb_age_stamp_alloc_3;

    localparam int DW = 8;
    localparam int AW = 5;

`ifdef AGE_STAMP_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic                 clk;
    logic                 rst;
    logic                 alloc_vld;
    logic                 alloc_rdy;
    logic [DW-1:0]        alloc_data;
    logic [2:0]           slot_vld;
    logic [2:0][AW-1:0]   slot_age;
    logic [2:0]           grant;
    logic                 iss_vld;
    logic [DW-1:0]        iss_data;
    logic [AW-1:0]        iss_age;
    logic                 err;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] age;
    } exp_t;

    exp_t q [$];
    int checks = 0;
    int errors = 0;

    age_stamp_alloc_3 dut (
        .clk        (clk),
        .rst        (rst),
        .alloc_vld  (alloc_vld),
        .alloc_rdy  (alloc_rdy),
        .alloc_data (alloc_data),
        .slot_vld   (slot_vld),
        .slot_age   (slot_age),
        .grant      (grant),
        .iss_vld    (iss_vld),
        .iss_data   (iss_data),
        .iss_age    (iss_age),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && iss_vld) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL iss_unexpected got data=%h age=%0d want none", iss_data, iss_age);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (iss_data !== e.data || iss_age !== e.age) begin
                    errors++;
                    $display("FAIL iss got data=%h age=%0d want data=%h age=%0d",
                             iss_data, iss_age, e.data, e.age);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_alloc(input logic [DW-1:0] d);
        alloc_vld  = 1'b1;
        alloc_data = d;
        tick();
        alloc_vld  = 1'b0;
    endtask

    task automatic do_grant(input logic [2:0] g, input logic [DW-1:0] d, input logic [AW-1:0] a);
        q.push_back('{data: d, age: a});
        grant = g;
        tick();
        grant = 3'b000;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        alloc_vld = 1'b0;
        alloc_data = '0;
        grant = 3'b000;
        tick();
        tick();
        checks++;
        if (slot_vld !== 3'b000 || iss_vld !== 1'b0 || err !== 1'b0 || slot_age !== '0) begin
            errors++;
            $display("FAIL reset got vld=%b iss=%b err=%b want 000 0 0", slot_vld, iss_vld, err);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (alloc_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_rdy got %b want 1", alloc_rdy);
        end
    endtask

    task automatic test_fill;
        alloc_vld = 1'b1;
        alloc_data = 8'hA1;
        tick();
        alloc_data = 8'hB2;
        tick();
        alloc_data = 8'hC3;
        tick();
        alloc_vld = 1'b0;
        checks++;
        if (slot_vld !== 3'b111 || slot_age[0] !== 5'd0 || slot_age[1] !== 5'd1
            || slot_age[2] !== 5'd2) begin
            errors++;
            $display("FAIL fill got vld=%b ages=%0d,%0d,%0d want 111 0,1,2",
                     slot_vld, slot_age[0], slot_age[1], slot_age[2]);
        end
        checks++;
        if (alloc_rdy !== 1'b0) begin
            errors++;
            $display("FAIL full_rdy got %b want 0", alloc_rdy);
        end
    endtask

    task automatic test_grant_full;
        do_grant(3'b001, 8'hA1, 5'd0);
        checks++;
        if (slot_vld !== 3'b110 || alloc_rdy !== 1'b1) begin
            errors++;
            $display("FAIL grant_full got vld=%b rdy=%b want 110 1", slot_vld, alloc_rdy);
        end
    endtask

    task automatic test_back_to_back;
        alloc_vld = 1'b1;
        alloc_data = 8'hD4;
        do_grant(3'b010, 8'hB2, 5'd1);
        alloc_vld = 1'b0;
        checks++;
        if (slot_vld !== 3'b101 || slot_age[0] !== 5'd3) begin
            errors++;
            $display("FAIL same_cycle got vld=%b age0=%0d want 101 3", slot_vld, slot_age[0]);
        end
    endtask

    task automatic test_rebase;
        do_grant(3'b001, 8'hD4, 5'd3);
        do_grant(3'b100, 8'hC3, 5'd2);
        for (int i = 0; i < 24; i++) begin
            do_alloc(8'h40 + 8'(i));
            do_grant(3'b001, 8'h40 + 8'(i), 5'(4 + i));
        end
        do_alloc(8'hE5);
        do_alloc(8'hF6);
        alloc_vld = 1'b1;
        alloc_data = 8'h67;
        do_grant(3'b010, 8'hF6, 5'd29);
        alloc_vld = 1'b0;
        checks++;
        if (alloc_rdy !== 1'b0 || slot_vld !== 3'b101 || slot_age[0] !== 5'd28
            || slot_age[2] !== 5'd30) begin
            errors++;
            $display("FAIL rebase_enter got rdy=%b vld=%b ages=%0d,%0d want 0 101 28,30",
                     alloc_rdy, slot_vld, slot_age[0], slot_age[2]);
        end
        tick();
        checks++;
        if (alloc_rdy !== 1'b1 || slot_age[0] !== 5'd0 || slot_age[2] !== 5'd2) begin
            errors++;
            $display("FAIL rebase_done got rdy=%b ages=%0d,%0d want 1 0,2",
                     alloc_rdy, slot_age[0], slot_age[2]);
        end
        do_alloc(8'h78);
        checks++;
        if (slot_vld !== 3'b111 || slot_age[1] !== 5'd3) begin
            errors++;
            $display("FAIL rebase_stamp got vld=%b age1=%0d want 111 3", slot_vld, slot_age[1]);
        end
        do_grant(3'b001, 8'hE5, 5'd0);
        do_grant(3'b010, 8'h78, 5'd3);
        do_grant(3'b100, 8'h67, 5'd2);
    endtask

    task automatic test_pinned;
        int exp_stamp;
        int p_age;
        do_alloc(8'h99);
        checks++;
        if (slot_age[0] !== 5'd4) begin
            errors++;
            $display("FAIL pin_start got age0=%0d want 4", slot_age[0]);
        end
        exp_stamp = 5;
        p_age = 4;
        for (int i = 0; i < 40; i++) begin
            if (exp_stamp == 31 && p_age == 0) break;
            checks++;
            if (alloc_rdy !== 1'b1) begin
                errors++;
                $display("FAIL pin_rdy iter %0d got %b want 1", i, alloc_rdy);
            end
            do_alloc(8'h80 + 8'(i));
            do_grant(3'b010, 8'h80 + 8'(i), 5'(exp_stamp));
            exp_stamp++;
            if (exp_stamp == 31 && p_age != 0) begin
                exp_stamp -= p_age;
                p_age = 0;
            end
        end
        tick();
        tick();
        tick();
        checks++;
        if (alloc_rdy !== 1'b0 || slot_vld !== 3'b001 || slot_age[0] !== 5'd0) begin
            errors++;
            $display("FAIL pinned got rdy=%b vld=%b age0=%0d want 0 001 0",
                     alloc_rdy, slot_vld, slot_age[0]);
        end
        do_grant(3'b001, 8'h99, 5'd0);
        checks++;
        if (alloc_rdy !== 1'b1 || slot_vld !== 3'b000) begin
            errors++;
            $display("FAIL unpin got rdy=%b vld=%b want 1 000", alloc_rdy, slot_vld);
        end
        do_alloc(8'h11);
        checks++;
        if (slot_age[0] !== 5'd0) begin
            errors++;
            $display("FAIL unpin_stamp got age0=%0d want 0", slot_age[0]);
        end
    endtask

    task automatic test_bad_grant;
        grant = 3'b100;
        tick();
        grant = 3'b000;
        checks++;
        if (iss_vld !== 1'b0) begin
            errors++;
            $display("FAIL invalid_grant got iss=%b want 0", iss_vld);
        end
        checks++;
        if (err !== ERR_EXP) begin
            errors++;
            $display("FAIL err_invalid got %b want %b", err, ERR_EXP);
        end
        do_alloc(8'h22);
        do_grant(3'b011, 8'h11, 5'd0);
        checks++;
        if (slot_vld !== 3'b010 || slot_age[1] !== 5'd1) begin
            errors++;
            $display("FAIL multi_grant got vld=%b age1=%0d want 010 1", slot_vld, slot_age[1]);
        end
        tick();
        tick();
        checks++;
        if (err !== ERR_EXP) begin
            errors++;
            $display("FAIL err_sticky got %b want %b", err, ERR_EXP);
        end
    endtask

    task automatic test_reset_mid;
        grant = 3'b010;
        tick();
        grant = 3'b000;
        rst = 1'b1;
        #1;
        checks++;
        if (iss_vld !== 1'b0 || slot_vld !== 3'b000 || err !== 1'b0 || alloc_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid got iss=%b vld=%b err=%b rdy=%b want 0 000 0 1",
                     iss_vld, slot_vld, err, alloc_rdy);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_grant_full();
        test_back_to_back();
        test_rebase();
        test_pinned();
        test_bad_grant();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
